// File: rtl/retire_multi_pkg.sv
// retire_multi_pkg: shared retire-stage types (package sys_defs)
package sys_defs;
    localparam int RT_WIDTH_DEF  = 2;
    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;

    typedef enum logic [1:0] {RT_RUN, RT_FLUSH, RT_HALTED} RT_STATE;

    typedef struct packed {
        logic                     valid;
        logic                     complete;
        logic [REG_IDX_W_DEF-1:0] r;
        logic [XLEN_DEF-1:0]      V;
        logic                     mispred;
        logic [XLEN_DEF-1:0]      target;
        logic                     halt;
    } RT_SLOT;

    typedef RT_SLOT [RT_WIDTH_DEF-1:0] ROB_RT_MULTI_PACKET;
endpackage

// File: rtl/retire_multi_select.sv
// rt_select: in-order retire mask, pop count and same-cycle WAW write-enable masking
module rt_select
    import sys_defs::*;
#(
    parameter int RT_WIDTH  = RT_WIDTH_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int PCW       = $clog2(RT_WIDTH + 1)
) (
    input  logic                          run,
    input  logic [RT_WIDTH-1:0]           valid,
    input  logic [RT_WIDTH-1:0]           complete,
    input  logic [RT_WIDTH-1:0]           mispred,
    input  logic [RT_WIDTH-1:0]           halt,
    input  logic [RT_WIDTH*REG_IDX_W-1:0] r,
    output logic [RT_WIDTH-1:0]           retire,
    output logic [RT_WIDTH-1:0]           en,
    output logic [PCW-1:0]                pop
);
    logic ok;

    // prefix chain: a slot retires only if every older slot retired and did not end the window
    always_comb begin
        ok     = run;
        retire = '0;
        en     = '0;
        pop    = '0;
        for (int i = 0; i < RT_WIDTH; i++) begin
            retire[i] = ok & valid[i] & complete[i];
            ok        = retire[i] & ~mispred[i] & ~halt[i];
            pop       = pop + PCW'(retire[i]);
        end
        for (int i = 0; i < RT_WIDTH; i++) begin
            en[i] = retire[i] && (r[i*REG_IDX_W +: REG_IDX_W] != '0);
            for (int j = i + 1; j < RT_WIDTH; j++)
                if (retire[j] && r[j*REG_IDX_W +: REG_IDX_W] == r[i*REG_IDX_W +: REG_IDX_W]) en[i] = 1'b0;
        end
    end
endmodule

// File: rtl/retire_multi.sv
// retire_multi: superscalar in-order retire stage; RETIRE_PERF_CNT_EN adds retire/flush counters
module retire_multi
    import sys_defs::*;
#(
    parameter int RT_WIDTH  = RT_WIDTH_DEF,
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [RT_WIDTH-1:0]               head_valid,
    input  logic [RT_WIDTH-1:0]               head_complete,
    input  logic [RT_WIDTH*REG_IDX_W-1:0]     head_r,
    input  logic [RT_WIDTH*XLEN-1:0]          head_V,
    input  logic [RT_WIDTH-1:0]               head_mispred,
    input  logic [RT_WIDTH*XLEN-1:0]          head_target,
    input  logic [RT_WIDTH-1:0]               head_halt,
    input  logic                              rob_empty,
    output logic [$clog2(RT_WIDTH+1)-1:0]     rt_pop_cnt,
    output logic [RT_WIDTH-1:0]               wb_regfile_en,
    output logic [RT_WIDTH*REG_IDX_W-1:0]     wb_regfile_idx,
    output logic [RT_WIDTH*XLEN-1:0]          wb_regfile_data,
    output logic                              flush,
    output logic [XLEN-1:0]                   redirect_pc,
`ifdef RETIRE_PERF_CNT_EN
    output logic [63:0]                       perf_retired,
    output logic [63:0]                       perf_flushes,
`endif
    output logic                              halted
);
    localparam int PCW = $clog2(RT_WIDTH + 1);

    RT_STATE             state, state_next;
    logic [RT_WIDTH-1:0] retire, en;
    logic [XLEN-1:0]     target;
    logic                take_mis, take_halt;

    rt_select #(.RT_WIDTH(RT_WIDTH), .REG_IDX_W(REG_IDX_W), .PCW(PCW)) u_sel (
        .run      (state == RT_RUN),
        .valid    (head_valid),
        .complete (head_complete),
        .mispred  (head_mispred),
        .halt     (head_halt),
        .r        (head_r),
        .retire   (retire),
        .en       (en),
        .pop      (rt_pop_cnt)
    );

    // halt outranks mispredict when the same slot carries both
    assign take_halt = |(retire & head_halt);
    assign take_mis  = |(retire & head_mispred) & ~take_halt;
    assign flush     = state == RT_FLUSH;
    assign halted    = state == RT_HALTED;

    // redirect target of the retiring mispredicted slot (at most one can retire)
    always_comb begin
        target = '0;
        for (int i = 0; i < RT_WIDTH; i++)
            if (retire[i] && head_mispred[i]) target = head_target[i*XLEN +: XLEN];
    end

    // next state: FLUSH retires nothing so it always falls back to RUN; HALTED is sticky
    always_comb begin
        state_next = state;
        state_next = (state == RT_HALTED || take_halt) ? RT_HALTED : take_mis ? RT_FLUSH : RT_RUN;
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RT_RUN;
        else       state <= state_next;
    end

    // writeback and redirect registers; idx/data hold for slots that do not retire
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_regfile_en   <= '0;
            wb_regfile_idx  <= '0;
            wb_regfile_data <= '0;
            redirect_pc     <= '0;
        end else begin
            wb_regfile_en <= en;
            for (int i = 0; i < RT_WIDTH; i++) begin
                if (retire[i]) begin
                    wb_regfile_idx[i*REG_IDX_W +: REG_IDX_W] <= head_r[i*REG_IDX_W +: REG_IDX_W];
                    wb_regfile_data[i*XLEN +: XLEN]          <= head_V[i*XLEN +: XLEN];
                end
            end
            if (take_mis) redirect_pc <= target;
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    // free-running performance counters, wrapping at 2^64
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_flushes <= '0;
        end else begin
            perf_retired <= perf_retired + 64'(rt_pop_cnt);
            perf_flushes <= perf_flushes + 64'(take_mis);
        end
    end
`endif

    a_empty_no_valid: assert property (@(posedge clock) disable iff (reset) rob_empty |-> head_valid == '0);
endmodule

// File: tb/tb_retire_multi.sv
// tb_retire_multi: directed self-checking bench for retire_multi (2-wide)
module tb_retire_multi;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  head_valid = '0, head_complete = '0, head_mispred = '0, head_halt = '0;
    logic [9:0]  head_r = '0;
    logic [63:0] head_V = '0, head_target = '0;
    logic        rob_empty = 1'b1;
    logic [1:0]  rt_pop_cnt;
    logic [1:0]  wb_regfile_en;
    logic [9:0]  wb_regfile_idx;
    logic [63:0] wb_regfile_data;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halted;
`ifdef RETIRE_PERF_CNT_EN
    logic [63:0] perf_retired, perf_flushes;
`endif
    int pass_cnt = 0;
    int total = 0;

    retire_multi dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_complete(head_complete), .head_r(head_r), .head_V(head_V),
        .head_mispred(head_mispred), .head_target(head_target), .head_halt(head_halt),
        .rob_empty(rob_empty), .rt_pop_cnt(rt_pop_cnt),
        .wb_regfile_en(wb_regfile_en), .wb_regfile_idx(wb_regfile_idx), .wb_regfile_data(wb_regfile_data),
        .flush(flush), .redirect_pc(redirect_pc),
`ifdef RETIRE_PERF_CNT_EN
        .perf_retired(perf_retired), .perf_flushes(perf_flushes),
`endif
        .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [1:0] v, c, m, h, input logic [4:0] r1, r0,
                         input logic [31:0] d1, d0, t1, t0);
        @(negedge clock);
        head_valid = v; head_complete = c; head_mispred = m; head_halt = h;
        head_r = {r1, r0}; head_V = {d1, d0}; head_target = {t1, t0};
        rob_empty = (v == 2'b00);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (wb_regfile_en !== 2'b00) $display("FAIL reset_en got %b exp 00", wb_regfile_en); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush); else pass_cnt++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else pass_cnt++;
        total++; if (redirect_pc !== 32'd0) $display("FAIL reset_redirect got %h exp 0", redirect_pc); else pass_cnt++;
        total++; if (rt_pop_cnt !== 2'd0) $display("FAIL reset_pop got %0d exp 0", rt_pop_cnt); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_dual();
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd7, 5'd3, 32'h22, 32'h11, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd2) $display("FAIL dual_pop got %0d exp 2", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (wb_regfile_en !== 2'b11) $display("FAIL dual_en got %b exp 11", wb_regfile_en); else pass_cnt++;
        total++; if (wb_regfile_idx !== {5'd7, 5'd3}) $display("FAIL dual_idx got %h exp %h", wb_regfile_idx, {5'd7, 5'd3}); else pass_cnt++;
        total++; if (wb_regfile_data !== {32'h22, 32'h11}) $display("FAIL dual_data got %h exp 0000002200000011", wb_regfile_data); else pass_cnt++;
    endtask

    task automatic test_stall();
        drive(2'b11, 2'b10, 2'b00, 2'b00, 5'd9, 5'd8, 32'h99, 32'h88, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd0) $display("FAIL stall_pop got %0d exp 0", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (wb_regfile_en !== 2'b00) $display("FAIL stall_en got %b exp 00", wb_regfile_en); else pass_cnt++;
        total++; if (wb_regfile_idx !== {5'd7, 5'd3}) $display("FAIL stall_idx_hold got %h exp %h", wb_regfile_idx, {5'd7, 5'd3}); else pass_cnt++;
    endtask

    task automatic test_mispredict();
        drive(2'b11, 2'b11, 2'b01, 2'b00, 5'd2, 5'd1, 32'h22, 32'h44, 32'd0, 32'h400);
        total++; if (rt_pop_cnt !== 2'd1) $display("FAIL mis_pop got %0d exp 1", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (flush !== 1'b1) $display("FAIL mis_flush got %b exp 1", flush); else pass_cnt++;
        total++; if (redirect_pc !== 32'h400) $display("FAIL mis_redirect got %h exp 400", redirect_pc); else pass_cnt++;
        total++; if (wb_regfile_en !== 2'b01) $display("FAIL mis_en got %b exp 01", wb_regfile_en); else pass_cnt++;
        total++; if (wb_regfile_data[31:0] !== 32'h44) $display("FAIL mis_link_data got %h exp 44", wb_regfile_data[31:0]); else pass_cnt++;
        total++; if (rt_pop_cnt !== 2'd0) $display("FAIL flush_pop got %0d exp 0", rt_pop_cnt); else pass_cnt++;
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd6, 5'd4, 32'h66, 32'h55, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd0) $display("FAIL flush_pop2 got %0d exp 0", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (flush !== 1'b0) $display("FAIL flush_drop got %b exp 0", flush); else pass_cnt++;
        total++; if (wb_regfile_en !== 2'b00) $display("FAIL flush_en got %b exp 00", wb_regfile_en); else pass_cnt++;
        total++; if (rt_pop_cnt !== 2'd2) $display("FAIL resume_pop got %0d exp 2", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (wb_regfile_idx !== {5'd6, 5'd4}) $display("FAIL resume_idx got %h exp %h", wb_regfile_idx, {5'd6, 5'd4}); else pass_cnt++;
        idle();
    endtask

    task automatic test_waw();
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd5, 5'd5, 32'hB, 32'hA, 32'd0, 32'd0);
        tick();
        total++; if (wb_regfile_en !== 2'b10) $display("FAIL waw_en got %b exp 10", wb_regfile_en); else pass_cnt++;
        total++; if (wb_regfile_data[63:32] !== 32'hB) $display("FAIL waw_data got %h exp b", wb_regfile_data[63:32]); else pass_cnt++;
        drive(2'b01, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'h77, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd1) $display("FAIL r0_pop got %0d exp 1", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (wb_regfile_en !== 2'b00) $display("FAIL r0_en got %b exp 00", wb_regfile_en); else pass_cnt++;
        idle();
    endtask

    task automatic test_halt();
        drive(2'b11, 2'b11, 2'b00, 2'b10, 5'd9, 5'd8, 32'h99, 32'h88, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd2) $display("FAIL halt_pop got %0d exp 2", rt_pop_cnt); else pass_cnt++;
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_rise got %b exp 1", halted); else pass_cnt++;
        total++; if (wb_regfile_en !== 2'b11) $display("FAIL halt_en got %b exp 11", wb_regfile_en); else pass_cnt++;
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd2, 5'd1, 32'h2, 32'h1, 32'd0, 32'd0);
        total++; if (rt_pop_cnt !== 2'd0) $display("FAIL halted_pop got %0d exp 0", rt_pop_cnt); else pass_cnt++;
        tick();
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b exp 1", halted); else pass_cnt++;
        total++; if (wb_regfile_en !== 2'b00) $display("FAIL halted_en got %b exp 00", wb_regfile_en); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (halted !== 1'b0) $display("FAIL halt_async_reset got %b exp 0", halted); else pass_cnt++;
        idle();
        reset = 1'b0;
        drive(2'b01, 2'b01, 2'b01, 2'b01, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h123);
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_mis_halted got %b exp 1", halted); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL halt_mis_flush got %b exp 0", flush); else pass_cnt++;
        do_reset();
    endtask

`ifdef RETIRE_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 9; i++)
            drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd2, 5'd1, 32'h2, 32'h1, 32'd0, 32'd0);
        drive(2'b11, 2'b11, 2'b10, 2'b00, 5'd2, 5'd1, 32'h2, 32'h1, 32'h800, 32'd0);
        idle();
        total++; if (perf_retired !== 64'd20) $display("FAIL perf_retired got %0d exp 20", perf_retired); else pass_cnt++;
        total++; if (perf_flushes !== 64'd1) $display("FAIL perf_flushes got %0d exp 1", perf_flushes); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_dual();
        test_stall();
        test_mispredict();
        test_waw();
        test_halt();
`ifdef RETIRE_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
